// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the control decoder.
package muldiv_pkg;

  localparam logic [3:0] ALU_CTRL_MUL = 4'b0100;
  localparam logic [3:0] ALU_CTRL_DIV = 4'b0101;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Iteration counter width; one bit minimum so a degenerate WIDTH still elaborates.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: out = neg ? -in : in.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit producing a HI/LO pair.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               dbz_q, dbz_d;

  logic               is_mul, is_div, accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH+1:0]   sub_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_mul = (alu_ctrl == ALU_CTRL_MUL);
  assign is_div = (alu_ctrl == ALU_CTRL_DIV);
  assign accept = (state_q == ST_IDLE) && start && (is_mul || is_div);

  muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (.in_i(op_a), .neg_i(op_a[WIDTH-1]), .out_o(abs_a));
  muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (.in_i(op_b), .neg_i(op_b[WIDTH-1]), .out_o(abs_b));

  muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .in_i(acc_q), .neg_i(sign_a_q ^ sign_b_q), .out_o(prod_fix)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .in_i(acc_q[WIDTH-1:0]), .neg_i(sign_a_q ^ sign_b_q), .out_o(quo_fix)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .in_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sign_a_q), .out_o(rem_fix)
  );

  // One iteration. MUL: acc = {partial_hi, multiplier}; DIV: acc = {remainder, dividend/quotient}.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    sub_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, opnd_q};
    if (div_q) begin
      if (!sub_diff[WIDTH+1]) acc_step = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                    acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {add_sum, acc_q[WIDTH-1:1]};
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          div_d    = is_div;
          sign_a_d = op_a[WIDTH-1];
          sign_b_d = op_b[WIDTH-1];
          opnd_d   = is_div ? abs_b : abs_a;
          acc_d    = {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
          cnt_d    = CW'(WIDTH - 1);
          dbz_d    = 1'b0;
          if (is_div && (op_b == '0)) begin
            lo_d    = '1;
            hi_d    = op_a;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        if (div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      div_q    <= div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done        = (state_q == ST_DONE);
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expected values are hand-computed constants.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alu_ctrl = 4'b0000;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives start for one cycle from a falling edge, then counts falling edges after the
  // accepting rising edge until done is seen (lat) and how many of them had busy high.
  // inj > 0 pulses a competing DIV 100/7 start on that cycle while the unit is busy.
  task automatic run_op(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj, output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1; alu_ctrl = ctrl; op_a = a; op_b = b;
    lat = 0; busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (inj != 0 && lat == inj) begin
        start = 1'b1; alu_ctrl = ALU_CTRL_DIV; op_a = 32'd100; op_b = 32'd7;
      end
      if (busy) busy_n++;
    end while (!done && lat < 200);
    start = 1'b0;
  endtask

  initial begin
    int lat, busy_n, seen_busy, seen_done;

    // Reset values.
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo", 64'(result_lo), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    // MUL 7 * -3 = -21: done 34 cycles after the edge preceding start, busy WIDTH+1 cycles.
    run_op(ALU_CTRL_MUL, 32'd7, 32'hFFFFFFFD, 0, lat, busy_n);
    check("mul_lat", 64'(lat), 64'd34);
    check("mul_busy_cycles", 64'(busy_n), 64'd33);
    check("mul_hi", 64'(result_hi), 64'hFFFFFFFF);
    check("mul_lo", 64'(result_lo), 64'hFFFFFFEB);
    check("mul_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    check("mul_done_pulse", 64'(done), 64'd0);
    check("mul_busy_after", 64'(busy), 64'd0);

    // Reset asserted at cycle 10 of a MUL drops the operation and clears the results.
    start = 1'b1; alu_ctrl = ALU_CTRL_MUL; op_a = 32'd7; op_b = 32'hFFFFFFFD;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrst_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_lo", 64'(result_lo), 64'd0);
    check("midrst_hi", 64'(result_hi), 64'd0);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("midrst_no_done", 64'(seen_done), 64'd0);

    // DIV -7 / 2: quotient -3, remainder takes the dividend sign (-1).
    run_op(ALU_CTRL_DIV, 32'hFFFFFFF9, 32'd2, 0, lat, busy_n);
    check("div_lat", 64'(lat), 64'd34);
    check("div_lo", 64'(result_lo), 64'hFFFFFFFD);
    check("div_hi", 64'(result_hi), 64'hFFFFFFFF);
    check("div_dbz", 64'(div_by_zero), 64'd0);

    // DIV 5 / 0: CALC/FIX skipped, done in the cycle after the accepting edge.
    run_op(ALU_CTRL_DIV, 32'd5, 32'd0, 0, lat, busy_n);
    check("dz_lat", 64'(lat), 64'd1);
    check("dz_busy_cycles", 64'(busy_n), 64'd0);
    check("dz_lo", 64'(result_lo), 64'hFFFFFFFF);
    check("dz_hi", 64'(result_hi), 64'd5);
    check("dz_flag", 64'(div_by_zero), 64'd1);

    // Competing start while busy is ignored; the original MUL result is delivered.
    run_op(ALU_CTRL_MUL, 32'd7, 32'hFFFFFFFD, 5, lat, busy_n);
    check("busy_start_lat", 64'(lat), 64'd34);
    check("busy_start_lo", 64'(result_lo), 64'hFFFFFFEB);
    check("busy_start_hi", 64'(result_hi), 64'hFFFFFFFF);
    check("busy_start_dbz_clr", 64'(div_by_zero), 64'd0);

    // Back-to-back: start in the IDLE cycle right after done. DIV 100 / -7 = -14 r 2.
    run_op(ALU_CTRL_DIV, 32'd100, 32'hFFFFFFF9, 0, lat, busy_n);
    check("b2b_lat", 64'(lat), 64'd34);
    check("b2b_lo", 64'(result_lo), 64'hFFFFFFF2);
    check("b2b_hi", 64'(result_hi), 64'd2);

    // DIV -2^31 / -1 wraps to -2^31 with zero remainder and no flag.
    run_op(ALU_CTRL_DIV, 32'h80000000, 32'hFFFFFFFF, 0, lat, busy_n);
    check("ovf_lo", 64'(result_lo), 64'h80000000);
    check("ovf_hi", 64'(result_hi), 64'd0);
    check("ovf_dbz", 64'(div_by_zero), 64'd0);

    // MUL -2^31 * -2^31 = 2^62 exactly.
    run_op(ALU_CTRL_MUL, 32'h80000000, 32'h80000000, 0, lat, busy_n);
    check("minmul_hi", 64'(result_hi), 64'h40000000);
    check("minmul_lo", 64'(result_lo), 64'd0);

    // Unsupported alu_ctrl: no busy, no done, results hold.
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    seen_busy = 0; seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) seen_busy++;
      if (done) seen_done++;
    end
    check("badop_busy", 64'(seen_busy), 64'd0);
    check("badop_done", 64'(seen_done), 64'd0);
    check("badop_hold_hi", 64'(result_hi), 64'h40000000);
    check("badop_hold_lo", 64'(result_lo), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
